costas_demod: RTL

Receive-side counterpart of the BPSK modulator: a Costas-loop carrier-recovery and BPSK demodulator.
- Mixes 10-bit ADC samples with local cos/sin from an external NCO instance, the same NCO IP used on the transmit side.
- Integrate-and-dumps the I and Q arms, forms a sign(I)·Q phase error and runs a PI loop filter.
- Drives the NCO's phi_inc_i with the corrected frequency word, and outputs the hard bit decision plus a lock flag.
- Sits between the ADC capture register and downstream bit processing.

---
 rtl/costas_demod.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/costas_demod.sv
// costas_demod
// Costas-loop carrier recovery and BPSK demodulator. Each ADC sample is mixed
// with the local cosine and sine from an external NCO. The I and Q arms are
// integrated and dumped once per DUMP_LEN valid samples. A sign(I)*Q phase
// error drives a PI loop filter. The filter output steers the NCO frequency
// word.
//
// Ports:
//   sys_clk, sys_rst_n  clock and asynchronous active-low reset
//   adc_in, adc_valid   signed received sample and its qualifier
//   nco_cos, nco_sin    signed local oscillator from the external NCO
//   phi_inc_o           frequency word fed back to the NCO phi_inc_i
//   i_out, q_out        latched I/Q integrator values, signed
//   dump_valid          one-cycle strobe marking new i_out/q_out/bit_out
//   bit_out             hard decision, 1 when i_out is negative
//   lock                carrier lock indicator
module costas_demod #(
  parameter int          DATA_W    = 10,
  parameter logic [31:0] FREQ_INIT = 32'd85899345,
  parameter int          DUMP_LEN  = 500,
  parameter int          ERR_SHIFT = 8,
  parameter int          KP_SHIFT  = 2,
  parameter int          KI_SHIFT  = 8,
  parameter int          LOCK_CNT  = 8
) (
  input  logic                                      sys_clk,
  input  logic                                      sys_rst_n,
  input  logic [DATA_W-1:0]                         adc_in,
  input  logic                                      adc_valid,
  input  logic [DATA_W-1:0]                         nco_cos,
  input  logic [DATA_W-1:0]                         nco_sin,
  output logic [31:0]                               phi_inc_o,
  output logic [2*DATA_W+$clog2(DUMP_LEN)-1:0]      i_out,
  output logic [2*DATA_W+$clog2(DUMP_LEN)-1:0]      q_out,
  output logic                                      dump_valid,
  output logic                                      bit_out,
  output logic                                      lock
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(DUMP_LEN);
  localparam int CNT_W  = $clog2(DUMP_LEN);
  localparam int LCNT_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(DUMP_LEN - 1);
  localparam logic [LCNT_W-1:0]       LCNT_LAST = LCNT_W'(LOCK_CNT - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [32:0]      INTEG_MAX = 33'sd1073741824;
  localparam logic signed [32:0]      INTEG_MIN = -33'sd1073741824;

  typedef enum logic {ACQUIRE, TRACK} state_t;

  logic signed [PROD_W-1:0] adc_x, cos_x, sin_x;
  logic signed [PROD_W-1:0] prod_i, prod_q;
  logic                     prod_valid;
  logic signed [ACC_W-1:0]  acc_i, acc_q, base_i, base_q;
  logic [CNT_W-1:0]         sample_cnt;
  logic                     dump_pend;

  logic signed [ACC_W-1:0]  i_s, q_s, q_sel;
  logic signed [31:0]       err, err_i, err_p, integ, integ_new;
  logic signed [32:0]       integ_sum;
  logic [ACC_W:0]           abs_i, abs_q;
  logic                     good;

  state_t                   state, next_state;
  logic [LCNT_W-1:0]        lock_cnt;
  logic [1:0]               miss_cnt;

  assign adc_x = PROD_W'($signed(adc_in));
  assign cos_x = PROD_W'($signed(nco_cos));
  assign sin_x = PROD_W'($signed(nco_sin));

  // Mixer stage: products are held while adc_valid is low so a gap never
  // disturbs the data already in flight.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prod_i     <= '0;
      prod_q     <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= adc_valid;
      if (adc_valid) begin
        prod_i <= adc_x * cos_x;
        prod_q <= adc_x * sin_x;
      end
    end
  end

  // On the dump cycle the integrators restart from zero, so a product that
  // arrives in that same cycle becomes the first sample of the next window.
  assign base_i = dump_pend ? '0 : acc_i;
  assign base_q = dump_pend ? '0 : acc_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_i      <= '0;
      acc_q      <= '0;
      sample_cnt <= '0;
      dump_pend  <= 1'b0;
      i_out      <= '0;
      q_out      <= '0;
      bit_out    <= 1'b0;
      dump_valid <= 1'b0;
    end else begin
      dump_valid <= dump_pend;
      if (dump_pend) begin
        i_out   <= acc_i;
        q_out   <= acc_q;
        bit_out <= acc_i[ACC_W-1];
      end
      if (prod_valid) begin
        acc_i      <= base_i + ACC_W'(prod_i);
        acc_q      <= base_q + ACC_W'(prod_q);
        sample_cnt <= (sample_cnt == CNT_LAST) ? '0 : sample_cnt + 1'b1;
        dump_pend  <= (sample_cnt == CNT_LAST);
      end else begin
        acc_i     <= base_i;
        acc_q     <= base_q;
        dump_pend <= 1'b0;
      end
    end
  end

  // Phase error sign(I)*Q. Negating the most-negative Q saturates instead of
  // wrapping back to itself.
  assign i_s   = i_out;
  assign q_s   = q_out;
  assign q_sel = !i_s[ACC_W-1] ? q_s : ((q_s == ACC_MIN) ? ACC_MAX : -q_s);
  assign err   = 32'(q_sel) >>> ERR_SHIFT;
  assign err_i = err >>> KI_SHIFT;
  assign err_p = err >>> KP_SHIFT;

  assign integ_sum = 33'(integ) + 33'(err_i);

  always_comb begin
    integ_new = integ_sum[31:0];
    if (integ_sum > INTEG_MAX)
      integ_new = INTEG_MAX[31:0];
    else if (integ_sum < INTEG_MIN)
      integ_new = INTEG_MIN[31:0];
  end

  // PI loop filter, updated once per dump; the frequency word holds otherwise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      integ     <= '0;
      phi_inc_o <= FREQ_INIT;
    end else if (dump_valid) begin
      integ     <= integ_new;
      phi_inc_o <= FREQ_INIT + integ_new + err_p;
    end
  end

  // A dump is good when the I arm clearly dominates: |I| > 2|Q|.
  assign abs_i = i_s[ACC_W-1] ? -(ACC_W+1)'(i_s) : (ACC_W+1)'(i_s);
  assign abs_q = q_s[ACC_W-1] ? -(ACC_W+1)'(q_s) : (ACC_W+1)'(q_s);
  assign good  = {1'b0, abs_i} > {abs_q, 1'b0};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      state <= ACQUIRE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (dump_valid) begin
      case (state)
        ACQUIRE: if (good && lock_cnt == LCNT_LAST) next_state = TRACK;
        TRACK:   if (!good && miss_cnt == 2'd3)      next_state = ACQUIRE;
        default: next_state = ACQUIRE;
      endcase
    end
  end

  always_comb begin
    lock = (state == TRACK);
  end

  // Good-dump and miss counters that qualify the lock state transitions.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_cnt <= '0;
      miss_cnt <= '0;
    end else if (dump_valid) begin
      if (state == ACQUIRE) begin
        miss_cnt <= '0;
        if (good)
          lock_cnt <= (lock_cnt == LCNT_LAST) ? '0 : lock_cnt + 1'b1;
        else
          lock_cnt <= '0;
      end else begin
        lock_cnt <= '0;
        if (good)
          miss_cnt <= '0;
        else
          miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

endmodule
